int_alu: RTL and testbench

- Registered integer ALU with WIDTH-bit operands (default 4) and a 4-bit opcode.
- Supports:
  - bitwise logic: AND, NAND, OR, NOR, XOR, XNOR, NOT
  - ADD and SUB with carry/borrow
  - MULT with a double-width result
  - DIV producing quotient and remainder
  - single-bit SHIFT with spill-out
- Primary result on out; secondary result (high product half / remainder / spilled bits) on out_2; carry/borrow/error on cout.
- Datapath leaf block; the surrounding control logic drives opcode and operands every cycle.

---
 rtl/int_alu_pkg.sv | 22 ++
 rtl/int_alu_divider.sv | 33 +++
 rtl/int_alu.sv | 112 +++++++++++
 tb/tb_int_alu.sv | 122 ++++++++++++
 4 files changed

// File: rtl/int_alu_pkg.sv
// Shared definitions for the registered integer ALU: opcode field width,
// opcode type and the opcode encodings.
package int_alu_pkg;

    localparam int OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_AND   = 4'h0;
    localparam opcode_t OP_NAND  = 4'h1;
    localparam opcode_t OP_OR    = 4'h2;
    localparam opcode_t OP_NOR   = 4'h3;
    localparam opcode_t OP_XOR   = 4'h4;
    localparam opcode_t OP_XNOR  = 4'h5;
    localparam opcode_t OP_NOT   = 4'h6;
    localparam opcode_t OP_ADD   = 4'h7;
    localparam opcode_t OP_SUB   = 4'h8;
    localparam opcode_t OP_MULT  = 4'h9;
    localparam opcode_t OP_DIV   = 4'hA;
    localparam opcode_t OP_SHIFT = 4'hB;

endpackage

// File: rtl/int_alu_divider.sv
// Combinational unsigned restoring divider. One trial subtraction per
// quotient bit, MSB first. A zero divisor is flagged; the caller decides
// what quotient/remainder to present in that case.
module int_alu_divider #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Partial remainder carries one extra bit so the shifted value never
    // overflows before the trial subtraction.
    logic [WIDTH:0] rem;

    // Restoring division: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem      = '0;
        quotient = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem         = rem - {1'b0, divisor};
                quotient[i] = 1'b1;
            end
        end
        remainder   = rem[WIDTH-1:0];
        div_by_zero = (divisor == '0);
    end

endmodule

// File: rtl/int_alu.sv
// Registered integer ALU: logic ops, add/sub with carry/borrow, double-width
// multiply, divide with remainder, single-bit shift with spill-out.
// One cycle of latency, a new operation every cycle.
// Optional: define INT_ALU_ZERO_FLAG_EN to add a registered 'zero' output
// that is set when the full {out_2,out} result is zero.
module int_alu
    import int_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  opcode_t          opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_2,
    output logic             cout
`ifdef INT_ALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_2;
    logic               res_c;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic               dbz;

    int_alu_divider #(.WIDTH(WIDTH)) u_div (
        .dividend    (a),
        .divisor     (b),
        .quotient    (quo),
        .remainder   (rmd),
        .div_by_zero (dbz)
    );

    // Shared arithmetic; the extra top bit of sum/diff is carry/borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    // Opcode decode into next-cycle result; unlisted opcodes give all zeros.
    always_comb begin
        res   = '0;
        res_2 = '0;
        res_c = 1'b0;
        case (opcode)
            OP_AND:  res = a & b;
            OP_NAND: res = ~(a & b);
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NOT:  res = ~a;
            OP_ADD:  {res_c, res} = sum;
            OP_SUB:  {res_c, res} = diff;
            OP_MULT: {res_2, res} = prod;
            OP_DIV: begin
                if (dbz) begin
                    res   = '1;
                    res_2 = a;
                    res_c = 1'b1;
                end else begin
                    res   = quo;
                    res_2 = rmd;
                end
            end
            OP_SHIFT: begin
                if (b[0]) begin
                    res   = {cin, a[WIDTH-1:1]};
                    res_2 = {{(WIDTH-1){1'b0}}, a[0]};
                end else begin
                    res   = {a[WIDTH-2:0], cin};
                    res_2 = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
                end
            end
            default: ;
        endcase
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            out_2 <= '0;
            cout  <= 1'b0;
        end else begin
            out   <= res;
            out_2 <= res_2;
            cout  <= res_c;
        end
    end

`ifdef INT_ALU_ZERO_FLAG_EN
    // Zero flag registered alongside the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero <= 1'b0;
        else        zero <= ({res_2, res} == '0);
    end
`endif

endmodule

// File: tb/tb_int_alu.sv
// Directed-vector bench for int_alu (WIDTH=4); expected values hand-computed.
module tb_int_alu;
    import int_alu_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    opcode_t      opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] out;
    logic [W-1:0] out_2;
    logic         cout;
`ifdef INT_ALU_ZERO_FLAG_EN
    logic         zero;
`endif

    int errs   = 0;
    int checks = 0;

    int_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .out    (out),
        .out_2  (out_2),
        .cout   (cout)
`ifdef INT_ALU_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one op away from the edge, then sample #1 after the capturing edge.
    task automatic run(input string tag, input opcode_t op, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic vc, input logic [W-1:0] eo,
                       input logic [W-1:0] eo2, input logic ec);
        @(negedge clk);
        opcode = op; a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
        chk({tag, ".out"},   out,   eo);
        chk({tag, ".out_2"}, out_2, eo2);
        chk({tag, ".cout"},  {3'b0, cout}, {3'b0, ec});
`ifdef INT_ALU_ZERO_FLAG_EN
        chk({tag, ".zero"},  {3'b0, zero}, {3'b0, ({eo2, eo} == 8'h00)});
`endif
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_AND; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out",   out,   4'b0000);
        chk("rst.out_2", out_2, 4'b0000);
        chk("rst.cout",  {3'b0, cout}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic ops
        run("and",  OP_AND,  4'b1010, 4'b1100, 1'b0, 4'b1000, 4'b0000, 1'b0);
        run("nand", OP_NAND, 4'b1010, 4'b1100, 1'b0, 4'b0111, 4'b0000, 1'b0);
        run("or",   OP_OR,   4'b1010, 4'b1100, 1'b0, 4'b1110, 4'b0000, 1'b0);
        run("nor",  OP_NOR,  4'b1010, 4'b1100, 1'b0, 4'b0001, 4'b0000, 1'b0);
        run("xor",  OP_XOR,  4'b1010, 4'b1100, 1'b0, 4'b0110, 4'b0000, 1'b0);
        run("xnor", OP_XNOR, 4'b1010, 4'b1100, 1'b0, 4'b1001, 4'b0000, 1'b0);
        run("not",  OP_NOT,  4'b1010, 4'b1100, 1'b0, 4'b0101, 4'b0000, 1'b0);

        // Add / subtract
        run("add",   OP_ADD, 4'd3,    4'd5,    1'b0, 4'b1000, 4'b0000, 1'b0);
        run("sub",   OP_SUB, 4'd3,    4'd5,    1'b0, 4'b1110, 4'b0000, 1'b1);
        run("addc",  OP_ADD, 4'b1111, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1);
        run("subbi", OP_SUB, 4'd5,    4'd3,    1'b1, 4'b0001, 4'b0000, 1'b0);
        run("subeq", OP_SUB, 4'd3,    4'd3,    1'b1, 4'b1111, 4'b0000, 1'b1);

        // Multiply / divide
        run("mul",   OP_MULT, 4'd3,  4'd4,  1'b0, 4'b1100, 4'b0000, 1'b0);
        run("mulff", OP_MULT, 4'd15, 4'd15, 1'b0, 4'b0001, 4'b1110, 1'b0);
        run("div",   OP_DIV,  4'd3,  4'd4,  1'b0, 4'b0000, 4'b0011, 1'b0);
        run("div13", OP_DIV,  4'd13, 4'd3,  1'b0, 4'b0100, 4'b0001, 1'b0);
        run("div0",  OP_DIV,  4'b0111, 4'd0, 1'b0, 4'b1111, 4'b0111, 1'b1);

        // Shift
        run("shl", OP_SHIFT, 4'b1010, 4'b0010, 1'b0, 4'b0100, 4'b0001, 1'b0);
        run("shr", OP_SHIFT, 4'b1010, 4'b0001, 1'b1, 4'b1101, 4'b0000, 1'b0);

        // Reserved opcode
        run("rsvd", 4'hC, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);

        // Load nonzero outputs, then assert reset between edges
        run("pre", OP_DIV, 4'b0111, 4'd0, 1'b0, 4'b1111, 4'b0111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.out",   out,   4'b0000);
        chk("mrst.out_2", out_2, 4'b0000);
        chk("mrst.cout",  {3'b0, cout}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        run("post", OP_ADD, 4'd1, 4'd2, 1'b0, 4'b0011, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
